// File: rtl/link_word_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : link_word_assembler_pkg
// Description : Shared router constants and the framing FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package link_word_assembler_pkg;

    localparam int NIB_W         = 4;
    localparam int WORD_W        = 28;
    localparam int NIBS          = WORD_W / NIB_W;
    localparam int ERR_CNT_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ASM  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/link_word_assembler_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; clear beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_MAX = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/link_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : link_word_assembler
// Description : Packs link nibbles into encoded words, flags framing faults.
// Revision    : 1.0 - initial release
// ============================================================================
module link_word_assembler
    import link_word_assembler_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 link_vld,
    input  logic                 link_sof,
    input  logic [NIB_W-1:0]     link_data,
    output logic                 link_rdy,
    output logic                 word_vld,
    output logic [WORD_W-1:0]    word,
    input  logic                 word_rdy,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    localparam int c_CNT_W    = $clog2(NIBS + 1);
    localparam int c_IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_SHIFT_W  = WORD_W - NIB_W;
    localparam logic [c_CNT_W-1:0]  c_LAST     = c_CNT_W'(NIBS - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_nib_cnt;
    logic [c_SHIFT_W-1:0]  r_shift;
    logic [c_IDLE_W-1:0]   r_idle_cnt;
    logic                  r_word_vld;
    logic [WORD_W-1:0]     r_word;
    logic                  r_frame_err;

    logic w_link_rdy;
    logic w_accept;
    logic w_fault;
    logic w_start;
    logic w_shift;
    logic w_complete;
    logic w_idle_inc;

    // Only the completing nibble waits for the output register to drain.
    assign w_link_rdy = !((r_state == ASM) && (r_nib_cnt == c_LAST) && r_word_vld && !word_rdy);
    assign w_accept   = link_vld && w_link_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fault     = 1'b0;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_complete  = 1'b0;
        w_idle_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (link_sof) begin
                        w_start     = 1'b1;
                        w_state_nxt = ASM;
                    end else begin
                        w_fault = 1'b1;
                    end
                end
            end
            ASM: begin
                if (w_accept) begin
                    if (link_sof) begin
                        w_fault = 1'b1;
                        w_start = 1'b1;
                    end else if (r_nib_cnt == c_LAST) begin
                        w_complete  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_shift = 1'b1;
                    end
                end else if (w_link_rdy) begin
                    // Stalled cycles fall outside this branch and never age the frame.
                    if (r_idle_cnt == c_IDLE_MAX) begin
                        w_fault     = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idle_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_nib_cnt   <= '0;
            r_shift     <= '0;
            r_idle_cnt  <= '0;
            r_word_vld  <= 1'b0;
            r_word      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            // The shifter holds the first NIBS-1 nibbles right-aligned.
            if (w_start) begin
                r_shift   <= {{(c_SHIFT_W-NIB_W){1'b0}}, link_data};
                r_nib_cnt <= c_CNT_W'(1);
            end else if (w_shift) begin
                r_shift   <= {r_shift[c_SHIFT_W-NIB_W-1:0], link_data};
                r_nib_cnt <= r_nib_cnt + c_CNT_W'(1);
            end else if (w_complete || w_fault) begin
                r_nib_cnt <= '0;
            end

            if (w_idle_inc) begin
                r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
            end else if (w_link_rdy) begin
                r_idle_cnt <= '0;
            end

            if (w_complete) begin
                r_word     <= {r_shift, link_data};
                r_word_vld <= 1'b1;
            end else if (word_rdy) begin
                r_word_vld <= 1'b0;
            end

            r_frame_err <= w_fault;
        end
    end

    sat_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_fault),
        .i_clr   (err_clr),
        .o_count (err_cnt)
    );

    assign link_rdy  = w_link_rdy;
    assign word_vld  = r_word_vld;
    assign word      = r_word;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_link_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_word_assembler
// Description : Directed per-cycle vector bench for link_word_assembler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_link_word_assembler;

    logic        clk;
    logic        rst;
    logic        link_vld;
    logic        link_sof;
    logic [3:0]  link_data;
    logic        link_rdy;
    logic        word_vld;
    logic [27:0] word;
    logic        word_rdy;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        err_clr;

    link_word_assembler dut (
        .clk       (clk),
        .rst       (rst),
        .link_vld  (link_vld),
        .link_sof  (link_sof),
        .link_data (link_data),
        .link_rdy  (link_rdy),
        .word_vld  (word_vld),
        .word      (word),
        .word_rdy  (word_rdy),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs driven in a cycle and the outputs expected during that same cycle.
    typedef struct {
        int          tag;
        logic        rst;
        logic        vld;
        logic        sof;
        logic [3:0]  data;
        logic        wrdy;
        logic        clr;
        logic        e_lrdy;
        logic        e_wvld;
        logic        chk_word;
        logic [27:0] e_word;
        logic        e_ferr;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_bad;

    function automatic void add(input int tag, input int r, input int vld, input int sof,
                                input logic [3:0] d, input int wrdy, input int clr,
                                input int e_lrdy, input int e_wvld, input logic [27:0] e_word,
                                input int chk, input int e_ferr, input int e_cnt);
        vec_t v;
        v.tag      = tag;
        v.rst      = (r != 0);
        v.vld      = (vld != 0);
        v.sof      = (sof != 0);
        v.data     = d;
        v.wrdy     = (wrdy != 0);
        v.clr      = (clr != 0);
        v.e_lrdy   = (e_lrdy != 0);
        v.e_wvld   = (e_wvld != 0);
        v.e_word   = e_word;
        v.chk_word = (chk != 0);
        v.e_ferr   = (e_ferr != 0);
        v.e_cnt    = 8'(e_cnt);
        tbl.push_back(v);
    endfunction

    initial begin
        logic [27:0] wa;
        logic [27:0] wb;
        logic [27:0] wc;
        logic [27:0] wd;
        logic        bad;

        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        link_vld  = 1'b0;
        link_sof  = 1'b0;
        link_data = 4'h0;
        word_rdy  = 1'b1;
        err_clr   = 1'b0;

        // Reset state
        add(0, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 1, 0, 0);

        // Single frame with immediate consume
        wa = 28'h123456A;
        for (int i = 0; i < 7; i++)
            add(1, 0, 1, int'(i == 0), wa[27-4*i -: 4], 1, 0, 1, 0, 28'h0, 0, 0, 0);
        add(1, 0, 0, 0, 4'h0, 1, 0, 1, 1, 28'h123456A, 1, 0, 0);
        add(1, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 0);

        // sof on the 4th nibble restarts the frame
        for (int i = 0; i < 3; i++)
            add(3, 0, 1, int'(i == 0), 4'(i + 1), 1, 0, 1, 0, 28'h0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            add(3, 0, 1, int'(i == 0), 4'h7, 1, 0, 1, 0, 28'h0, 0, int'(i == 1), int'(i >= 1));
        add(3, 0, 0, 0, 4'h0, 1, 0, 1, 1, 28'h7777777, 1, 0, 1);
        add(3, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 1);

        // Back-to-back frames, first word held for 10 cycles
        wa = 28'hABCDEF0;
        wb = 28'h1234567;
        for (int i = 0; i < 7; i++)
            add(2, 0, 1, int'(i == 0), wa[27-4*i -: 4], 0, 0, 1, 0, 28'h0, 0, 0, 1);
        for (int i = 0; i < 6; i++)
            add(2, 0, 1, int'(i == 0), wb[27-4*i -: 4], 0, 0, 1, 1, wa, 1, 0, 1);
        for (int k = 0; k < 4; k++)
            add(2, 0, 1, 0, wb[3:0], 0, 0, 0, 1, wa, 1, 0, 1);
        add(2, 0, 1, 0, wb[3:0], 1, 0, 1, 1, wa, 1, 0, 1);
        add(2, 0, 0, 0, 4'h0, 1, 0, 1, 1, wb, 1, 0, 1);
        add(2, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 1);

        // Stall after 3 nibbles: fault lands on the 16th idle cycle
        for (int i = 0; i < 3; i++)
            add(4, 0, 1, int'(i == 0), 4'(i + 1), 1, 0, 1, 0, 28'h0, 0, 0, 1);
        for (int i = 1; i <= 18; i++)
            add(4, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, int'(i == 17), (i >= 17) ? 2 : 1);
        wa = 28'h89ABCDE;
        for (int i = 0; i < 7; i++)
            add(4, 0, 1, int'(i == 0), wa[27-4*i -: 4], 1, 0, 1, 0, 28'h0, 0, 0, 2);
        add(4, 0, 0, 0, 4'h0, 1, 0, 1, 1, 28'h89ABCDE, 1, 0, 2);
        add(4, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 2);

        // Long backpressure stall must not be mistaken for an idle timeout
        wc = 28'h1111111;
        wd = 28'h2222222;
        for (int i = 0; i < 7; i++)
            add(5, 0, 1, int'(i == 0), 4'h1, 0, 0, 1, 0, 28'h0, 0, 0, 2);
        for (int i = 0; i < 6; i++)
            add(5, 0, 1, int'(i == 0), 4'h2, 0, 0, 1, 1, wc, 1, 0, 2);
        for (int k = 0; k < 20; k++)
            add(5, 0, 1, 0, 4'h2, 0, 0, 0, 1, wc, 1, 0, 2);
        add(5, 0, 1, 0, 4'h2, 1, 0, 1, 1, wc, 1, 0, 2);
        add(5, 0, 0, 0, 4'h0, 1, 0, 1, 1, wd, 1, 0, 2);
        add(5, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 2);

        // Stray nibbles saturate the counter; clear wins over a same-cycle fault
        for (int k = 0; k < 300; k++)
            add(6, 0, 1, 0, 4'h5, 1, 0, 1, 0, 28'h0, 0, int'(k > 0), (2 + k > 255) ? 255 : 2 + k);
        add(6, 0, 1, 0, 4'h5, 1, 1, 1, 0, 28'h0, 0, 1, 255);
        add(6, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 1, 0);
        add(6, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 0);

        // Reset mid-frame clears everything, then a clean frame follows
        add(7, 0, 1, 0, 4'h9, 1, 0, 1, 0, 28'h0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add(7, 0, 1, int'(i == 0), 4'(i + 1), 1, 0, 1, 0, 28'h0, 0, int'(i == 0), 1);
        add(7, 1, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 1);
        add(7, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 1, 0, 0);
        wa = 28'h6789ABC;
        for (int i = 0; i < 7; i++)
            add(7, 0, 1, int'(i == 0), wa[27-4*i -: 4], 1, 0, 1, 0, 28'h0, 0, 0, 0);
        add(7, 0, 0, 0, 4'h0, 1, 0, 1, 1, 28'h6789ABC, 1, 0, 0);
        add(7, 0, 0, 0, 4'h0, 1, 0, 1, 0, 28'h0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;

        if ((link_rdy !== 1'b1) || (word_vld !== 1'b0) || (word !== 28'h0) ||
            (frame_err !== 1'b0) || (err_cnt !== 8'h0)) begin
            n_bad = n_bad + 1;
            $display("FAIL reset state: lrdy=%b wvld=%b word=%h ferr=%b cnt=%0d",
                     link_rdy, word_vld, word, frame_err, err_cnt);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            rst       = tbl[i].rst;
            link_vld  = tbl[i].vld;
            link_sof  = tbl[i].sof;
            link_data = tbl[i].data;
            word_rdy  = tbl[i].wrdy;
            err_clr   = tbl[i].clr;
            @(negedge clk);
            n_vec = n_vec + 1;
            bad = (link_rdy !== tbl[i].e_lrdy) || (word_vld !== tbl[i].e_wvld) ||
                  (frame_err !== tbl[i].e_ferr) || (err_cnt !== tbl[i].e_cnt) ||
                  (tbl[i].chk_word && (word !== tbl[i].e_word));
            if (bad) begin
                n_bad = n_bad + 1;
                $display("FAIL vec %0d tag %0d: got lrdy=%b wvld=%b word=%h ferr=%b cnt=%0d, exp lrdy=%b wvld=%b word=%h(chk=%b) ferr=%b cnt=%0d",
                         i, tbl[i].tag, link_rdy, word_vld, word, frame_err, err_cnt,
                         tbl[i].e_lrdy, tbl[i].e_wvld, tbl[i].e_word, tbl[i].chk_word,
                         tbl[i].e_ferr, tbl[i].e_cnt);
            end
            if ((tbl[i].tag == 4) && tbl[i].e_ferr) begin
                if ((frame_err !== 1'b1) || (word_vld !== 1'b0) || (err_cnt !== tbl[i].e_cnt)) begin
                    n_bad = n_bad + 1;
                    $display("FAIL vec %0d: expired-wait fault missing, ferr=%b wvld=%b cnt=%0d",
                             i, frame_err, word_vld, err_cnt);
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad == 0)
            $display("PASS");
        else
            $display("FAIL");
        $finish;
    end

endmodule
`default_nettype wire
